// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one finished reservation station per cycle.
// Round-robin among completed requesters, with a starvation override that
// favours the lowest-index requester whose wait age has reached AGE_MAX.
// Arbitration is combinational and all outputs are registered, so the grant
// appears one cycle after complete is seen.
module cdb_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int BASE_ID = 1,
  parameter int AGE_MAX = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] complete,
  input  logic               stall,
  input  logic               flush,
  output logic [31:0]        selection,
  output logic               sel_load,
  output logic [NUM_REQ-1:0] grant_onehot
);

  localparam int          PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0]  AGE_TH = 4'(AGE_MAX);
  localparam logic [31:0] BASE   = 32'(BASE_ID);

  logic [31:0]        sel_q, sel_d;
  logic               load_q, load_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [3:0]         age_q [NUM_REQ];
  logic [3:0]         age_d [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic               starv_hit, rr_hit, do_grant;
  logic [PTR_W-1:0]   starv_idx, rr_idx, winner;

  // Pick the winner: starved requesters first (lowest index), else round-robin from rr_q.
  always_comb begin
    int j;
    j         = 0;
    // The requester currently on the bus is drained this cycle, so it sits out.
    elig      = complete & ~(load_q ? grant_q : '0);
    starv_hit = 1'b0;
    starv_idx = '0;
    rr_hit    = 1'b0;
    rr_idx    = '0;
    // Downward scans so that the last hit written is the lowest index / nearest offset.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i] && (age_q[i] >= AGE_TH)) begin
        starv_hit = 1'b1;
        starv_idx = PTR_W'(i);
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (elig[PTR_W'(j)]) begin
        rr_hit = 1'b1;
        rr_idx = PTR_W'(j);
      end
    end
    winner   = starv_hit ? starv_idx : rr_idx;
    do_grant = (starv_hit | rr_hit) & ~stall & ~flush;
  end

  // Next-state for outputs, round-robin pointer and age counters.
  always_comb begin
    sel_d   = '0;
    load_d  = 1'b0;
    grant_d = '0;
    rr_d    = rr_q;
    if (do_grant) begin
      sel_d   = BASE + 32'(winner);
      load_d  = 1'b1;
      grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
      rr_d    = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (flush || !complete[i] || (do_grant && (winner == PTR_W'(i))))
        age_d[i] = 4'd0;
      else if (age_q[i] != 4'hf)
        age_d[i] = age_q[i] + 4'd1;
      else
        age_d[i] = age_q[i];
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q   <= '0;
      load_q  <= 1'b0;
      grant_q <= '0;
      rr_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= 4'd0;
    end else begin
      sel_q   <= sel_d;
      load_q  <= load_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= age_d[i];
    end
  end

  assign selection    = sel_q;
  assign sel_load     = load_q;
  assign grant_onehot = grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: the driver steps a behavioural model and
// queues the expected registered outputs; a monitor compares every cycle.
module tb_cdb_arbiter;

  localparam int N    = 8;
  localparam int BASE = 1;
  localparam int AMAX = 7;

  typedef struct {
    logic        ld;
    logic [31:0] sel;
    logic [N-1:0] gnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] complete;
  logic         stall;
  logic         flush;
  logic [31:0]  selection;
  logic         sel_load;
  logic [N-1:0] grant_onehot;

  int errors = 0;
  int checks = 0;

  exp_t q[$];

  // Reference model state
  int           m_rr;
  int           m_age[N];
  logic         m_ld;
  logic [N-1:0] m_gnt;

  cdb_arbiter #(.NUM_REQ(N), .BASE_ID(BASE), .AGE_MAX(AMAX)) dut (
    .clk(clk), .reset_n(reset_n), .complete(complete), .stall(stall),
    .flush(flush), .selection(selection), .sel_load(sel_load),
    .grant_onehot(grant_onehot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_ld = 1'b0;
    m_gnt = '0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  // One cycle of the arbitration rules, expressed over integers.
  task automatic model_step(input logic [N-1:0] c, input logic s, input logic f);
    exp_t e;
    logic [N-1:0] elig;
    int w;
    int granted;
    elig = c & ~(m_ld ? m_gnt : '0);
    w = -1;
    for (int i = 0; i < N; i++)
      if (w < 0 && elig[i] && m_age[i] >= AMAX) w = i;
    if (w < 0)
      for (int k = 0; k < N; k++)
        if (w < 0 && elig[(m_rr + k) % N]) w = (m_rr + k) % N;
    e.ld = 1'b0; e.sel = '0; e.gnt = '0;
    granted = -1;
    if (!f && !s && w >= 0) begin
      e.ld = 1'b1;
      e.sel = BASE + w;
      e.gnt[w] = 1'b1;
      m_rr = (w + 1) % N;
      granted = w;
    end
    for (int i = 0; i < N; i++) begin
      if (f || !c[i] || i == granted) m_age[i] = 0;
      else if (m_age[i] < 15) m_age[i] = m_age[i] + 1;
    end
    m_ld = e.ld;
    m_gnt = e.gnt;
    q.push_back(e);
  endtask

  // Called at posedge+2; drives inputs, predicts the next edge, advances one cycle.
  task automatic step(input logic [N-1:0] c, input logic s, input logic f);
    complete = c;
    stall = s;
    flush = f;
    model_step(c, s, f);
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic reset_pulse();
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_sel_load", {31'b0, sel_load}, 32'd0);
    check("async_rst_selection", selection, 32'd0);
    check("async_rst_grant", {24'b0, grant_onehot}, 32'd0);
    q.delete();
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: compare registered outputs just after each active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("sel_load", {31'b0, sel_load}, {31'b0, e.ld});
      check("selection", selection, e.sel);
      check("grant_onehot", {24'b0, grant_onehot}, {24'b0, e.gnt});
    end
  end

  initial begin
    reset_n  = 1'b0;
    complete = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    model_reset();
    #1;
    check("reset_sel_load", {31'b0, sel_load}, 32'd0);
    check("reset_selection", selection, 32'd0);
    check("reset_grant", {24'b0, grant_onehot}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Move rr_ptr to 2, then wrap-around search: expect 8, 1, 2.
    step(8'b0000_0010, 1'b0, 1'b0);
    repeat (3) step(8'b1000_0011, 1'b0, 1'b0);

    // Reset while a grant is on the bus, then a lone requester 4 -> selection 5.
    reset_pulse();
    step(8'b0001_0000, 1'b0, 1'b0);
    repeat (2) step(8'b0000_0000, 1'b0, 1'b0);

    // From reset with requesters 0 and 2 held: 1, 3, 1, 3.
    reset_pulse();
    repeat (4) step(8'b0000_0101, 1'b0, 1'b0);

    // Long stall builds age past the starvation threshold.
    repeat (8) step(8'b0000_0011, 1'b1, 1'b0);
    repeat (3) step(8'b0000_0011, 1'b0, 1'b0);

    // Flush against a pending grant, then stall+flush together.
    step(8'b0000_0110, 1'b0, 1'b1);
    repeat (2) step(8'b0000_0110, 1'b0, 1'b0);
    step(8'b0000_0110, 1'b1, 1'b1);
    step(8'b0000_0110, 1'b0, 1'b0);

    // Single requester held.
    repeat (6) step(8'b0000_0001, 1'b0, 1'b0);

    // All requesters at once.
    repeat (10) step(8'b1111_1111, 1'b0, 1'b0);

    // Randomised traffic with occasional stalls and flushes.
    for (int n = 0; n < 400; n++)
      step(N'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));

    step(8'b0000_0000, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
